// File: rtl/ysyx_24120013_pkg.sv
// Shared definitions for the ysyx_24120013 multi-cycle core.
// Holds the sequencer state encoding and the PC constants.
package ysyx_24120013_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } seq_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/ysyx_24120013_mc_seq.sv
// Multi-cycle instruction sequencer: owns PC and instruction register, walks
// fetch/decode/execute/writeback, and halts on ebreak or on a fault.
module ysyx_24120013_mc_seq
    import ysyx_24120013_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifetch_req,
    output logic [XLEN-1:0]   ifetch_addr,
    input  logic              ifetch_ack,
    input  logic [INST_W-1:0] ifetch_data,
    input  logic              ifetch_err,
    output logic [INST_W-1:0] inst,
    output logic              exu_start,
    input  logic              exu_done,
    input  logic              exu_wen,
    input  logic              exu_jmp_en,
    input  logic [XLEN-1:0]   exu_jmp_target,
    input  logic              exu_halt,
    output logic              rf_wen,
    output logic [XLEN-1:0]   pc,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              halted,
    output logic              halt_err
);

    seq_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halt_err_q, halt_err_d;
    logic              first_q, first_d;
    logic              wen_q, wen_d;
    logic              jmp_q, jmp_d;
    logic              halt_q, halt_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              misaligned;

    // A taken jump to a non word-aligned target is a fault, not a retire.
    assign misaligned = exu_jmp_en && (exu_jmp_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            cnt_q      <= '0;
            halt_err_q <= 1'b0;
            first_q    <= 1'b0;
            wen_q      <= 1'b0;
            jmp_q      <= 1'b0;
            halt_q     <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            halt_err_q <= halt_err_d;
            first_q    <= first_d;
            wen_q      <= wen_d;
            jmp_q      <= jmp_d;
            halt_q     <= halt_d;
            target_q   <= target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        cnt_d      = cnt_q;
        halt_err_d = halt_err_q;
        first_d    = first_q;
        wen_d      = wen_q;
        jmp_d      = jmp_q;
        halt_d     = halt_q;
        target_d   = target_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ifetch_ack) begin
                    if (ifetch_err) begin
                        state_d    = S_HALT;
                        halt_err_d = 1'b1;
                    end else begin
                        inst_d  = ifetch_data;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                first_d = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                first_d = 1'b0;
                if (exu_done) begin
                    if (misaligned) begin
                        state_d    = S_HALT;
                        halt_err_d = 1'b1;
                    end else begin
                        wen_d    = exu_wen;
                        jmp_d    = exu_jmp_en;
                        target_d = exu_jmp_target;
                        halt_d   = exu_halt;
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                cnt_d   = cnt_q + CNT_W'(1);
                pc_d    = jmp_q ? target_q : pc_q + XLEN'(PC_INC);
                state_d = halt_q ? S_HALT : S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode registered state only, so no input reaches them combinationally.
    assign ifetch_req  = (state_q == S_FETCH);
    assign ifetch_addr = pc_q;
    assign exu_start   = (state_q == S_EXEC) && first_q;
    assign retire      = (state_q == S_WB);
    assign rf_wen      = (state_q == S_WB) && wen_q && !halt_q;
    assign halted      = (state_q == S_HALT);
    assign halt_err    = halt_err_q;
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_ysyx_24120013_mc_seq.sv
// Randomized scoreboard bench for the multi-cycle sequencer: a driver plays
// memory and EXU, a monitor compares DUT strobes against queued expectations.
module tb_ysyx_24120013_mc_seq;
    import ysyx_24120013_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct packed {
        logic        wen;
        logic [31:0] cnt;
    } retireItem_t;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } haltItem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ifetch_ack = 1'b0;
    logic [31:0] ifetch_data = '0;
    logic        ifetch_err = 1'b0;
    logic [31:0] inst;
    logic        exu_start;
    logic        exu_done = 1'b0;
    logic        exu_wen = 1'b0;
    logic        exu_jmp_en = 1'b0;
    logic [31:0] exu_jmp_target = '0;
    logic        exu_halt = 1'b0;
    logic        rf_wen;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] retire_cnt;
    logic        halted;
    logic        halt_err;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;
    bit lostSync = 0;
    bit prevHalted = 0;

    logic [31:0] modelPc;
    logic [31:0] modelInst;
    logic [31:0] modelCnt;
    logic [31:0] fetchQ[$];
    logic [31:0] instQ[$];
    retireItem_t retireQ[$];
    haltItem_t   haltQ[$];
    retireItem_t ri;
    haltItem_t   hi;

    ysyx_24120013_mc_seq #(
        .XLEN(32),
        .RESET_PC(RST_PC),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifetch_req(ifetch_req),
        .ifetch_addr(ifetch_addr),
        .ifetch_ack(ifetch_ack),
        .ifetch_data(ifetch_data),
        .ifetch_err(ifetch_err),
        .inst(inst),
        .exu_start(exu_start),
        .exu_done(exu_done),
        .exu_wen(exu_wen),
        .exu_jmp_en(exu_jmp_en),
        .exu_jmp_target(exu_jmp_target),
        .exu_halt(exu_halt),
        .rf_wen(rf_wen),
        .pc(pc),
        .retire(retire),
        .retire_cnt(retire_cnt),
        .halted(halted),
        .halt_err(halt_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flagUnexpected(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: DUT event with no expected entry", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ifetch_ack     = 1'b0;
        ifetch_data    = '0;
        ifetch_err     = 1'b0;
        exu_done       = 1'b0;
        exu_wen        = 1'b0;
        exu_jmp_en     = 1'b0;
        exu_jmp_target = '0;
        exu_halt       = 1'b0;
    endtask

    task automatic garbageExu(input bit done);
        exu_done       = done;
        exu_wen        = 1'($urandom_range(0, 1));
        exu_jmp_en     = 1'($urandom_range(0, 1));
        exu_jmp_target = $urandom;
        exu_halt       = 1'($urandom_range(0, 1));
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst) begin
            if (ifetch_req && ifetch_ack) begin
                if (fetchQ.size() == 0) flagUnexpected("fetchAck");
                else checkOutput("fetchAddr", ifetch_addr, fetchQ.pop_front());
            end
            if (exu_start) begin
                if (instQ.size() == 0) flagUnexpected("exuStart");
                else checkOutput("instAtStart", inst, instQ.pop_front());
            end
            if (retire) begin
                if (retireQ.size() == 0) flagUnexpected("retire");
                else begin
                    ri = retireQ.pop_front();
                    checkOutput("rfWen", rf_wen, ri.wen);
                    checkOutput("retireCnt", retire_cnt, ri.cnt);
                end
            end else if (rf_wen) begin
                flagUnexpected("rfWenNoRetire");
            end
            if (halted && !prevHalted) begin
                if (haltQ.size() == 0) flagUnexpected("halt");
                else begin
                    hi = haltQ.pop_front();
                    checkOutput("haltErr", halt_err, hi.err);
                    checkOutput("haltPc", pc, hi.pc);
                    checkOutput("haltInst", inst, hi.inst);
                    checkOutput("haltCnt", retire_cnt, hi.cnt);
                end
            end
        end
        prevHalted = halted;
    end

    task automatic doReset();
        checkOutput("queuesDrained", fetchQ.size() + instQ.size() + retireQ.size() + haltQ.size(), 0);
        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("resetDropsReq", ifetch_req, 0);
        tick();
        tick();
        checkOutput("resetPc", pc, RST_PC);
        checkOutput("resetInst", inst, 0);
        checkOutput("resetCnt", retire_cnt, 0);
        checkOutput("resetHalted", {halted, halt_err}, 0);
        checkOutput("resetStrobes", {ifetch_req, exu_start, rf_wen, retire}, 0);
        fetchQ.delete();
        instQ.delete();
        retireQ.delete();
        haltQ.delete();
        modelPc   = RST_PC;
        modelInst = '0;
        modelCnt  = '0;
        lostSync  = 0;
        // A stale memory response arriving in the idle cycle must be ignored.
        ifetch_ack  = 1'b1;
        ifetch_data = $urandom;
        ifetch_err  = 1'($urandom_range(0, 1));
        rst = 1'b1;
        #1;
        checkOutput("idleNoReq", ifetch_req, 0);
        tick();
        checkOutput("firstReqTiming", ifetch_req, 1);
        clearInputs();
    endtask

    // One instruction: fetch with fw wait cycles, EXU with ew wait cycles.
    task automatic applyStimulus(input int fw, input bit err, input int ew, input bit wen,
                                 input bit jmp, input logic [31:0] tgt, input bit hlt,
                                 output bit stop);
        logic [31:0] data;
        int guard;
        stop  = 1;
        guard = 0;
        while (!ifetch_req && guard < 50) begin
            tick();
            guard++;
        end
        if (!ifetch_req) begin
            flagUnexpected("fetchReqTimeout");
            lostSync = 1;
            return;
        end
        for (int i = 0; i < fw; i++) begin
            ifetch_ack = 1'b0;
            garbageExu(1'($urandom_range(0, 1)));
            tick();
        end
        data        = $urandom;
        ifetch_ack  = 1'b1;
        ifetch_data = data;
        ifetch_err  = err;
        garbageExu(1'($urandom_range(0, 1)));
        fetchQ.push_back(modelPc);
        if (err) begin
            haltQ.push_back('{1'b1, modelPc, modelInst, modelCnt});
            tick();
            clearInputs();
            return;
        end
        modelInst = data;
        instQ.push_back(data);
        tick();
        ifetch_ack  = 1'($urandom_range(0, 1));
        ifetch_data = $urandom;
        ifetch_err  = 1'($urandom_range(0, 1));
        garbageExu(1'b1);
        tick();
        for (int i = 0; i < ew; i++) begin
            checkOutput("exuStartPulse", exu_start, (i == 0));
            ifetch_ack  = 1'($urandom_range(0, 1));
            ifetch_data = $urandom;
            ifetch_err  = 1'($urandom_range(0, 1));
            garbageExu(1'b0);
            tick();
        end
        checkOutput("exuStartPulse", exu_start, (ew == 0));
        checkOutput("instHeld", inst, modelInst);
        checkOutput("pcHeld", pc, modelPc);
        exu_done       = 1'b1;
        exu_wen        = wen;
        exu_jmp_en     = jmp;
        exu_jmp_target = tgt;
        exu_halt       = hlt;
        ifetch_ack     = 1'($urandom_range(0, 1));
        if (jmp && tgt[1:0] != 2'b00) begin
            haltQ.push_back('{1'b1, modelPc, modelInst, modelCnt});
            tick();
            clearInputs();
            checkOutput("faultNoRetire", retire, 0);
            return;
        end
        retireQ.push_back('{wen & ~hlt, modelCnt});
        modelCnt = modelCnt + 1;
        modelPc  = jmp ? tgt : modelPc + 32'd4;
        if (hlt) haltQ.push_back('{1'b0, modelPc, modelInst, modelCnt});
        tick();
        checkOutput("retireTiming", retire, 1);
        clearInputs();
        ifetch_ack = 1'($urandom_range(0, 1));
        tick();
        clearInputs();
        stop = hlt;
    endtask

    task automatic checkHaltQuiet(input bit expErr);
        int activity;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            ifetch_ack = 1'($urandom_range(0, 1));
            garbageExu(1'($urandom_range(0, 1)));
            if (ifetch_req || exu_start || rf_wen || retire || !halted) activity++;
            tick();
        end
        clearInputs();
        checkOutput("haltQuiet", activity, 0);
        checkOutput("haltErrSticky", halt_err, expErr);
        checkOutput("haltCntFrozen", retire_cnt, modelCnt);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        bit stop;
        int startCycle;
        int fw, ew;
        bit err, jmp, hlt, wen;
        logic [31:0] tgt;

        // Sequential run with two fetch waits, then a jump and a mid-fetch reset.
        doReset();
        startCycle = cycleCount;
        for (int n = 0; n < 5; n++) applyStimulus(2, 0, 0, 1, 0, $urandom, 0, stop);
        checkOutput("fiveInstrCycles", cycleCount - startCycle, 30);
        checkOutput("fiveInstrCnt", retire_cnt, 5);
        applyStimulus(0, 0, 1, 1, 1, 32'h8000_0100, 0, stop);
        checkOutput("jumpAddr", ifetch_addr, 32'h8000_0100);
        applyStimulus(1, 0, 2, 0, 0, 32'h0000_0003, 0, stop);
        ifetch_ack = 1'b0;
        checkOutput("midFetchReq", ifetch_req, 1);

        // Misaligned jump target faults without retiring.
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, stop);
        applyStimulus(1, 0, 1, 1, 1, 32'h8000_0102, 0, stop);
        if (!lostSync) checkHaltQuiet(1);

        // ebreak retires once with the write suppressed.
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, stop);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, stop);
        if (!lostSync) checkHaltQuiet(0);

        // Fetch bus fault.
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, stop);
        applyStimulus(3, 1, 0, 1, 0, 0, 0, stop);
        if (!lostSync) checkHaltQuiet(1);

        // PC wraps modulo 2^32.
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, stop);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, stop);
        checkOutput("pcWrap", ifetch_addr, 32'h0000_0000);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, stop);

        for (int ep = 0; ep < 20; ep++) begin
            doReset();
            stop = 0;
            err  = 0;
            jmp  = 0;
            tgt  = '0;
            for (int n = 0; n < 15 && !stop; n++) begin
                fw  = $urandom_range(0, 3);
                ew  = $urandom_range(0, 3);
                err = ($urandom_range(0, 99) < 3);
                jmp = ($urandom_range(0, 3) == 0);
                tgt = $urandom;
                if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
                hlt = ($urandom_range(0, 24) == 0);
                wen = 1'($urandom_range(0, 1));
                applyStimulus(fw, err, ew, wen, jmp, tgt, hlt, stop);
            end
            if (stop && !lostSync) checkHaltQuiet(err || (jmp && tgt[1:0] != 2'b00));
        end

        doReset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ysyx_24120013_mc_seq.md
# ysyx_24120013_mc_seq

Multi-cycle instruction sequencer for the ysyx_24120013 core; replaces the free-running PC of the single-cycle top. Owns the PC, instruction register, and a stage FSM (fetch, decode, execute, writeback). Fetches over a req/ack handshake so memory latency is arbitrary, and gates register-file writes to one cycle per instruction. Handles jump redirect, ebreak halt and fault halt, and counts retired instructions. Sits between the instruction memory port and the IDU/EXU/RegisterFile.

## Interface
- XLEN, 32, address/data width of PC and jump target
- RESET_PC, 32'h8000_0000, PC value loaded at reset
- CNT_W, 32, width of retire counter

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ifetch_req  out  1  fetch request; high only in S_FETCH
- ifetch_addr  out  XLEN  fetch address, equals pc
- ifetch_ack  in  1  fetch complete; data/err valid this cycle
- ifetch_data  in  32  instruction word
- ifetch_err  in  1  bus fault, qualified by ifetch_ack
- inst  out  32  instruction register to IDU
- exu_start  out  1  one-cycle pulse entering S_EXEC
- exu_done  in  1  EXU result valid
- exu_wen  in  1  EXU requests rd write
- exu_jmp_en  in  1  taken jump/branch, qualified by exu_done
- exu_jmp_target  in  XLEN  redirect target
- exu_halt  in  1  ebreak decoded, qualified by exu_done
- rf_wen  out  1  gated register-file write enable
- pc  out  XLEN  current PC
- retire  out  1  one-cycle pulse per retired instruction
- retire_cnt  out  CNT_W  retired-instruction count
- halted  out  1  sticky, core stopped
- halt_err  out  1  sticky, stop caused by fault

## Operation
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT.
- Reset values: state=S_IDLE, pc=RESET_PC, inst=0, retire_cnt=0, halted=0, halt_err=0. All strobes (ifetch_req, exu_start, rf_wen, retire) are 0.
- S_IDLE: unconditionally goes to S_FETCH next cycle.
- S_FETCH: ifetch_req=1 and ifetch_addr=pc, held stable until ack.
  - On ack with err=0: inst<=ifetch_data, go to S_DECODE.
  - On ack with err=1: go to S_HALT with halt_err<=1; inst unchanged.
- S_DECODE: one cycle so the IDU/regfile read settles on the new inst, then go to S_EXEC.
- S_EXEC: exu_start=1 on the first cycle only. Wait for exu_done, then latch wen, jmp_en, target and halt into internal registers and go to S_WB.
  - If jmp_en=1 and target[1:0]!=0: go to S_HALT with halt_err<=1; no write, no retire, pc unchanged.
- S_WB: one cycle.
  - rf_wen = latched wen & ~latched halt.
  - retire=1 and retire_cnt increments.
  - pc <= jmp_en ? target : pc+4.
  - Go to S_HALT if the latched halt is set, else S_FETCH.
- S_HALT: terminal until reset. halted=1; no requests or strobes.
- PC arithmetic is modulo 2^XLEN (0xFFFF_FFFC+4 = 0). retire_cnt wraps modulo 2^CNT_W.
- Ignored inputs:
  - ifetch_ack outside S_FETCH.
  - exu_done outside S_EXEC (including in the exu_start cycle's predecessor).
  - exu_jmp_en, exu_halt and exu_wen unless exu_done=1.
- Reset asserted mid-operation: all state returns to reset values immediately (async); ifetch_req drops in the same cycle. A pending memory response after release is ignored until the new S_FETCH.

## Timing
- Zero-wait case: ack in the first S_FETCH cycle and done in the exu_start cycle give 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
- Each fetch wait cycle and each EXU wait cycle adds one cycle.
- First ifetch_req rises 1 cycle after reset release (S_IDLE).
- inst is valid from the S_DECODE cycle until the next fetch ack.
- pc updates on the clock edge ending S_WB; the new ifetch_addr is presented in the following S_FETCH.
- rf_wen and retire are coincident, one cycle wide, registered-state decodes (no input-to-output combinational path).
- halted asserts the cycle after S_WB (ebreak) or after the faulting ack/done edge.

## Structure
- Shared package ysyx_24120013_pkg holds:
  - the state enum;
  - RESET_PC default;
  - INST_W=32 and the PC increment constant 4.
- Single module, no sub-modules. The retire counter is inline and is not worth splitting out.

## Test plan
- Reset with 2 fetch wait states, 5 sequential non-jump instructions with exu_wen=1, done same cycle:
  - ifetch_addr goes 0x8000_0000, 0x8000_0004, and so on;
  - five rf_wen pulses, each coincident with retire;
  - retire_cnt=5 after 30 cycles.
- Jump with jmp_en=1, target=0x8000_0100: next ifetch_addr=0x8000_0100; the target 0x8000_0102 variant gives halted=1, halt_err=1, no retire, pc unchanged.
- ebreak (exu_halt=1, exu_wen=1): one retire, rf_wen=0, halted=1, halt_err=0; ifetch_req stays 0 for 20 cycles.
- ifetch_err=1 on ack: halted=1, halt_err=1, inst unchanged, retire_cnt unchanged.
- Spurious ifetch_ack in S_EXEC and spurious exu_done in S_FETCH: no state change; inst and pc are unaffected.
- rst pulsed low while ifetch_req=1 with RESET_PC=0x0 and pc=0x40: ifetch_req falls in the same cycle, pc=0x0, and the first fetch after release is addr 0x0.
